// File: rtl/frame_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : frame_capture_if
// Summary  : Tagged pixel stream (valid/ready, pixel, start-of-line, end-of-frame).
// Revision : 1.0 - initial release
// ============================================================================
interface frame_capture_if #(
    parameter int PIXEL_W = 8
);
    logic               out_valid;
    logic               out_ready;
    logic [PIXEL_W-1:0] out_data;
    logic               out_sol;
    logic               out_eof;

    modport master (
        output out_valid,
        output out_data,
        output out_sol,
        output out_eof,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_sol,
        input  out_eof,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/frame_capture.sv
`default_nettype none
// ============================================================================
// Module   : frame_capture
// Summary  : Frames the PPU pixel stream on h/v rising edges and queues tagged
//            pixels in a first-word-fall-through FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module frame_capture #(
    parameter int PIXEL_W    = 8,
    parameter int ACTIVE_W   = 256,
    parameter int ACTIVE_H   = 240,
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PIXEL_W-1:0] pixel_in,
    input  logic               h,
    input  logic               v,
    input  logic               arm,
    input  logic               continuous,
    frame_capture_if.master    out_if,
    output logic               busy,
    output logic               overflow,
    output logic [15:0]        frame_count
);
    localparam int c_X_W   = $clog2(ACTIVE_W) + 1;
    localparam int c_Y_W   = $clog2(ACTIVE_H) + 1;
    localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_A_W   = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_A_W + 1;
    localparam int c_ENT_W = PIXEL_W + 2;

    localparam logic [c_X_W-1:0]   c_X_LAST   = c_X_W'(ACTIVE_W - 1);
    localparam logic [c_Y_W-1:0]   c_Y_LAST   = c_Y_W'(ACTIVE_H - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_WAIT_V = 3'd1;
    localparam logic [2:0] c_LINE   = 3'd2;
    localparam logic [2:0] c_WAIT_H = 3'd3;
    localparam logic [2:0] c_END    = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [c_DIV_W-1:0] r_div;
    logic               r_h_d;
    logic               r_v_d;
    logic [c_X_W-1:0]   r_x;
    logic [c_Y_W-1:0]   r_y;
    logic [15:0]        r_frame_count;
    logic               r_overflow;

    logic [c_ENT_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_A_W-1:0]   r_wr_ptr;
    logic [c_A_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_pix_en, w_h_rise, w_v_rise, w_x_last, w_y_last;
    logic w_sample, w_sol, w_eof, w_full, w_push, w_pop, w_valid;
    logic [c_ENT_W-1:0] w_head;

    assign w_pix_en = (r_div == '0);
    assign w_h_rise = h & ~r_h_d;
    assign w_v_rise = v & ~r_v_d;
    assign w_x_last = (r_x == c_X_LAST);
    assign w_y_last = (r_y == c_Y_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
            r_h_d <= 1'b0;
            r_v_d <= 1'b0;
        end else begin
            r_div <= (r_div == c_DIV_LAST) ? '0 : r_div + 1'b1;
            r_h_d <= h;
            r_v_d <= v;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            c_IDLE:   if (arm)      w_state_next = c_WAIT_V;
            c_WAIT_V: if (w_v_rise) w_state_next = c_LINE;
            c_WAIT_H: if (w_h_rise) w_state_next = c_LINE;
            c_LINE:   w_state_next = c_LINE;
            c_END:    w_state_next = continuous ? c_WAIT_V : c_IDLE;
            default:  w_state_next = c_IDLE;
        endcase
        // The closing sample of a line may coincide with the entering edge.
        if (w_sample && w_x_last)
            w_state_next = w_y_last ? c_END : c_WAIT_H;
    end

    always_comb begin
        w_sample = w_pix_en & ((r_state == c_LINE) |
                               ((r_state == c_WAIT_V) & w_v_rise) |
                               ((r_state == c_WAIT_H) & w_h_rise));
        w_sol    = (r_x == '0);
        w_eof    = w_x_last & w_y_last;
        busy     = (r_state != c_IDLE);
    end

    // Counters advance even when the FIFO rejects the sample, keeping geometry intact.
    always_ff @(posedge clk) begin
        if (rst || r_state == c_IDLE || r_state == c_END) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_sample) begin
            if (w_x_last) begin
                r_x <= '0;
                r_y <= w_y_last ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_count <= '0;
            r_overflow    <= 1'b0;
        end else begin
            if (r_state == c_END)
                r_frame_count <= r_frame_count + 16'd1;
            if (r_state == c_IDLE && arm)
                r_overflow <= 1'b0;
            else if (w_sample && w_full)
                r_overflow <= 1'b1;
        end
    end

    assign frame_count = r_frame_count;
    assign overflow    = r_overflow;

    // Fullness is judged on the occupancy at the start of the cycle only.
    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == c_CNT_FULL);
    assign w_push  = w_sample & ~w_full;
    assign w_pop   = w_valid & out_if.out_ready;

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {w_eof, w_sol, pixel_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head           = r_mem[r_rd_ptr];
    assign out_if.out_valid = w_valid;
    assign out_if.out_data  = w_valid ? w_head[PIXEL_W-1:0] : '0;
    assign out_if.out_sol   = w_valid & w_head[PIXEL_W];
    assign out_if.out_eof   = w_valid & w_head[PIXEL_W+1];
endmodule
`default_nettype wire

// File: tb/tb_frame_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_capture
// Summary  : Randomised self-checking bench for frame_capture (4x3 frame, /4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_capture;
    localparam int PW = 8, W = 4, H = 3, DIV = 4, DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] pixel_in = '0;
    logic          h = 1'b0, v = 1'b0, arm = 1'b0, continuous = 1'b0;
    logic          busy, overflow;
    logic [15:0]   frame_count;

    frame_capture_if #(.PIXEL_W(PW)) bus ();

    frame_capture #(
        .PIXEL_W(PW), .ACTIVE_W(W), .ACTIVE_H(H), .CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .pixel_in(pixel_in), .h(h), .v(v), .arm(arm),
        .continuous(continuous), .out_if(bus), .busy(busy), .overflow(overflow),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int       checks = 0, errors = 0;
    int       k, cur_line, line_cnt, total_cnt, exp_fc;
    bit       in_line, busy_watch, busy_dropped;
    bit [9:0] exp_q[$];
    bit [9:0] got_q[$];
    bit [9:0] want;

    // Reference: a line captures the pixels present on the first W pixel-clock
    // edges (every DIV-th edge since reset release) from its start edge onwards.
    task automatic step();
        @(negedge clk);
        if (!rst && bus.out_valid && bus.out_ready)
            got_q.push_back({bus.out_eof, bus.out_sol, bus.out_data});
        @(posedge clk);
        if (in_line && (k % DIV == 0) && line_cnt < W) begin
            exp_q.push_back({(cur_line == H-1) && (line_cnt == W-1), line_cnt == 0, pixel_in});
            line_cnt++;
            total_cnt++;
        end
        k++;
        #1;
        if (busy_watch && busy !== 1'b1) busy_dropped = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1; arm = 1'b0; h = 1'b0; v = 1'b0; continuous = 1'b0;
        in_line = 1'b0; bus.out_ready = 1'b1; busy_watch = 1'b0;
        step(); step();
        rst = 1'b0; k = 0; exp_fc = 0;
        exp_q.delete(); got_q.delete();
    endtask

    task automatic do_arm();
        arm = 1'b1; step(); arm = 1'b0;
    endtask

    task automatic wait_outputs(input int n);
        for (int i = 0; i < 200 && got_q.size() < n; i++) begin
            pixel_in = 8'($urandom); step();
        end
        step(); step();
    endtask

    task automatic run_frame(input bit seq, input bit spurious, input int stop_after);
        int gap, hold;
        total_cnt = 0;
        gap = $urandom_range(1, 4);
        for (int i = 0; i < gap; i++) begin pixel_in = 8'($urandom); step(); end
        if (spurious) begin
            h = 1'b1; step(); h = 1'b0; step(); step();
        end
        for (int l = 0; l < H; l++) begin
            hold = (spurious && l == 1) ? 10 : $urandom_range(1, 3);
            cur_line = l; line_cnt = 0; in_line = 1'b1;
            if (l == 0) v = 1'b1; else h = 1'b1;
            for (int c = 0; c < W*DIV; c++) begin
                if (c == hold) begin v = 1'b0; h = 1'b0; end
                pixel_in = seq ? 8'(8'h10 + l*W + ((line_cnt < W) ? line_cnt : W-1)) : 8'($urandom);
                step();
                if (stop_after >= 0 && total_cnt >= stop_after) return;
            end
            in_line = 1'b0; v = 1'b0; h = 1'b0;
            gap = $urandom_range(1, 5);
            for (int i = 0; i < gap; i++) begin
                v = (spurious && l < H-1 && i == 0);
                pixel_in = 8'($urandom); step();
            end
            v = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin pixel_in = 8'($urandom); step(); end
        exp_fc++;
    endtask

    task automatic test_reset();
        rst = 1'b1; arm = 1'b1; bus.out_ready = 1'b1; in_line = 1'b0; busy_watch = 1'b0;
        step(); step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
        checks++; if ({bus.out_eof, bus.out_sol, bus.out_data} !== 10'h0) begin errors++; $display("FAIL reset_head: got %h expected 000", {bus.out_eof, bus.out_sol, bus.out_data}); end
        checks++; if ({busy, overflow} !== 2'b00) begin errors++; $display("FAIL reset_busy_ovf: got %b expected 00", {busy, overflow}); end
        checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_fc: got %0d expected 0", frame_count); end
        rst = 1'b0; arm = 1'b0; k = 0; exp_q.delete(); got_q.delete();
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_beats_arm: busy got %b expected 0", busy); end
    endtask

    task automatic test_one_shot();
        do_reset();
        do_arm();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL oneshot_busy_rise: got %b expected 1", busy); end
        run_frame(1'b1, 1'b0, -1);
        wait_outputs(12);
        checks++; if (got_q.size() != 12) begin errors++; $display("FAIL oneshot_count: got %0d expected 12", got_q.size()); end
        for (int i = 0; i < 12 && i < got_q.size(); i++) begin
            want = {i == 11, (i % 4) == 0, 8'(8'h10 + i)};
            checks++; if (got_q[i] !== want) begin errors++; $display("FAIL oneshot_out[%0d]: got %h expected %h", i, got_q[i], want); end
        end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL oneshot_fc: got %0d expected 1", frame_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL oneshot_busy_fall: got %b expected 0", busy); end
    endtask

    task automatic test_pix_en_alignment();
        do_reset();
        for (int f = 0; f < 2; f++) begin
            do_arm();
            run_frame(1'b0, 1'b0, -1);
        end
        wait_outputs(24);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL align_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL align_out[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (frame_count !== 16'(exp_fc)) begin errors++; $display("FAIL align_fc: got %0d expected %0d", frame_count, exp_fc); end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.out_ready = 1'b0;
        do_arm();
        run_frame(1'b0, 1'b0, -1);
        checks++; if (bus.out_valid !== 1'b1 || {bus.out_eof, bus.out_sol, bus.out_data} !== exp_q[0]) begin
            errors++; $display("FAIL bp_head: got %b/%h expected 1/%h", bus.out_valid, {bus.out_eof, bus.out_sol, bus.out_data}, exp_q[0]); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow: got %b expected 1", overflow); end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL bp_fc: got %0d expected 1", frame_count); end
        do_arm();
        checks++; if ({overflow, busy} !== 2'b01) begin errors++; $display("FAIL bp_rearm: ovf,busy got %b expected 01", {overflow, busy}); end
        bus.out_ready = 1'b1;
        wait_outputs(DEPTH);
        checks++; if (got_q.size() != DEPTH) begin errors++; $display("FAIL bp_kept: got %0d expected %0d", got_q.size(), DEPTH); end
        for (int i = 0; i < DEPTH && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_out[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_continuous();
        do_reset();
        continuous = 1'b1;
        do_arm();
        busy_watch = 1'b1; busy_dropped = 1'b0;
        for (int f = 0; f < 3; f++) run_frame(1'b0, 1'b0, -1);
        wait_outputs(36);
        busy_watch = 1'b0;
        checks++; if (busy_dropped !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL cont_busy: dropped %b busy %b expected 0 1", busy_dropped, busy); end
        checks++; if (frame_count !== 16'd3) begin errors++; $display("FAIL cont_fc: got %0d expected 3", frame_count); end
        checks++; if (got_q.size() != 36) begin errors++; $display("FAIL cont_count: got %0d expected 36", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL cont_out[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_spurious_sync();
        do_reset();
        do_arm();
        run_frame(1'b0, 1'b1, -1);
        wait_outputs(12);
        checks++; if (got_q.size() != 12) begin errors++; $display("FAIL sync_count: got %0d expected 12", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL sync_out[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL sync_fc: got %0d expected 1", frame_count); end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        do_arm();
        run_frame(1'b1, 1'b0, 6);
        rst = 1'b1; in_line = 1'b0; v = 1'b0; h = 1'b0;
        step();
        checks++; if ({bus.out_valid, busy} !== 2'b00) begin errors++; $display("FAIL midrst_state: valid,busy got %b expected 00", {bus.out_valid, busy}); end
        checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL midrst_fc: got %0d expected 0", frame_count); end
        rst = 1'b0; k = 0; exp_fc = 0; exp_q.delete(); got_q.delete();
        do_arm();
        run_frame(1'b1, 1'b0, -1);
        wait_outputs(12);
        checks++; if (got_q.size() != 12) begin errors++; $display("FAIL midrst_count: got %0d expected 12", got_q.size()); end
        for (int i = 0; i < 12 && i < got_q.size(); i++) begin
            want = {i == 11, (i % 4) == 0, 8'(8'h10 + i)};
            checks++; if (got_q[i] !== want) begin errors++; $display("FAIL midrst_out[%0d]: got %h expected %h", i, got_q[i], want); end
        end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL midrst_fc2: got %0d expected 1", frame_count); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.out_ready = 1'b1;
        test_reset();
        test_one_shot();
        test_pix_en_alignment();
        test_backpressure();
        test_continuous();
        test_spurious_sync();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/frame_capture.md
# frame_capture

Synthesizable, parametrised capture engine for the PPU pixel stream. Samples `pixel_in` on the PPU pixel-clock enable derived from `clk`, frames the data using rising edges of `h` and `v`, and delivers exactly ACTIVE_W × ACTIVE_H tagged pixels per frame through a FIFO with a valid/ready output. It sits beside `NES` in the top level and feeds the frame-dump or debug-UART path. It supports one-shot and continuous modes, and reports overflow.

## Interface
- PIXEL_W, 8, pixel index width
- ACTIVE_W, 256, pixels captured per line
- ACTIVE_H, 240, lines captured per frame
- CLK_DIV, 4, `clk` cycles per pixel-clock enable (≥1)
- FIFO_DEPTH, 16, output FIFO entries (power of two, ≥2)
- clk  input  1  system clock; single clock domain
- rst  input  1  synchronous, active-high reset
- pixel_in  input  PIXEL_W  pixel index from PPU
- h  input  1  line sync; rising edge starts a line
- v  input  1  frame sync; rising edge starts a frame
- arm  input  1  single-cycle pulse; starts a capture
- continuous  input  1  when 1, re-arm automatically after each frame (sampled at frame end)
- out_valid  output  1  FIFO head valid
- out_ready  input  1  downstream accepts head
- out_data  output  PIXEL_W  head pixel
- out_sol  output  1  head is first pixel of a line
- out_eof  output  1  head is last pixel of a frame
- busy  output  1  state ≠ IDLE
- overflow  output  1  sticky; a sample was dropped
- frame_count  output  16  completed frames, wraps at 65535→0

## Operation
- Divider: `div` counts 0..CLK_DIV-1 and wraps; it resets to 0. `pix_en = (div==0)`, so pix_en is high in the first cycle after reset release. With CLK_DIV=1, pix_en is always 1.
- Edge detect: `h_d`/`v_d` registered each cycle. `h_rise = h & ~h_d`, `v_rise = v & ~v_d`. Both are evaluated every `clk`, independent of pix_en.
- Counters: `x` has ⌈log2 ACTIVE_W⌉+1 bits and `y` has ⌈log2 ACTIVE_H⌉+1 bits. Both are cleared on entry to WAIT_V.
- State machine:
  - IDLE: on `arm` → WAIT_V. `arm` is ignored in every other state.
  - WAIT_V: on `v_rise` → LINE with x=0, y=0.
  - LINE: on each pix_en cycle, sample `pixel_in` and increment x.
    - sol=(x==0); eof=(x==ACTIVE_W-1 && y==ACTIVE_H-1).
    - After sample x==ACTIVE_W-1:
      - if y==ACTIVE_H-1 → END;
      - else y+=1, x=0 → WAIT_H.
  - WAIT_H: on `h_rise` → LINE. A `v_rise` here is ignored.
  - END (one cycle): frame_count+=1. If `continuous` → WAIT_V, else → IDLE.
- Sampling: a sample is taken in the same cycle as a state transition into LINE if pix_en is high that cycle. Edges that occur while in LINE are ignored.
- FIFO:
  - Entries are {eof, sol, pixel}.
  - A push is accepted only if occupancy < FIFO_DEPTH at the start of the cycle. A pop in the same cycle does not free space for that push.
  - A rejected push drops the sample and sets `overflow`. Capture counters still advance, so the frame geometry is preserved.
  - A pop occurs when out_valid & out_ready.
  - The FIFO is first-word-fall-through. out_valid = occupancy≠0.
- `overflow` clears on accepted `arm` or on `rst`.
- The FIFO is not flushed by `arm`.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_sol=0, out_eof=0
  - busy=0, overflow=0, frame_count=0
  - state IDLE, FIFO empty, div=0, h_d=v_d=0
- `rst` in mid-frame aborts the capture immediately and empties the FIFO. It has priority over all other inputs.
- Latency: a sample taken in cycle N appears at the FIFO head with out_valid=1 in cycle N+1 when the FIFO was empty.
- Throughput: 1 pop per cycle. With CLK_DIV ≥ 1, the FIFO never overflows if out_ready is held at 1.
- busy rises the cycle after `arm` and falls the cycle after END in one-shot mode.
- Simultaneous `arm` and `rst`: reset wins.
- Simultaneous push and pop with the FIFO non-full: both occur and occupancy is unchanged.

## Test plan
Parameters for the directed tests: ACTIVE_W=4, ACTIVE_H=3, CLK_DIV=4, FIFO_DEPTH=4.
- One-shot frame:
  - Stimulus: arm, v pulse, then three lines each with an h pulse; pixel_in = 8'h10+pixel number; out_ready=1.
  - Required response: exactly 12 outputs with data 8'h10..8'h1B; out_sol on the 1st, 5th and 9th outputs; out_eof only on the 12th; frame_count=1; busy=0 afterwards.
- Pixel-enable alignment:
  - Stimulus: pixel_in changes every clk.
  - Required response: captured values are only those present on cycles where div==0, with 4-cycle spacing.
- Backpressure/overflow:
  - Stimulus: out_ready=0 for the whole frame.
  - Required response: the FIFO holds the first 4 pixels; overflow=1; frame_count still reaches 1. A later arm clears overflow.
- Continuous mode:
  - Stimulus: continuous=1, one arm, 3 frames.
  - Required response: 36 outputs; frame_count=3; busy stays 1.
- Spurious sync:
  - Stimulus: an h pulse while in WAIT_V; a v pulse while in WAIT_H; h held high for 10 cycles.
  - Required response: no extra lines, and exactly one line start per rising edge.
- Reset mid-frame:
  - Stimulus: assert rst after 6 pixels.
  - Required response: next cycle out_valid=0, busy=0, frame_count=0. A re-arm then captures a clean 12-pixel frame.
